kmc_clkctl: RTL and testbench
=============================

Name: kmc_clkctl

Overview:
KMC11 microcycle clock controller; sits directly upstream of the KMC11 sequencer. Converts the maintenance-register controls (RUN, STEP, CRAM IN/OUT/WR) into the per-phase clock enables the sequencer and ALU consume.
- Outputs: kmcCRAMCLKEN, kmcALUCLKEN, kmcPCCLKEN and a one-clock CRAM write strobe.
- Provides free-running execution, exactly-one-microinstruction single step, and maintenance CRAM writes.

Parameters:
CLKDIV, 4, clk cycles per microcycle; legal range 3..16.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
kmcINIT  in  1  device initialize; synchronous clear, same effect as rst
kmcRUN  in  1  run bit (level) from maintenance CSR
kmcSTEP  in  1  step bit (level) from maintenance CSR; action taken on its rising edge
kmcCRAMIN  in  1  execute maintenance instruction instead of the CRAM word
kmcCRAMOUT  in  1  CRAM write enable from maintenance CSR
kmcCRAMWR  in  1  CRAM write bit (level); action taken on its rising edge
kmcCRAMCLKEN  out  1  load CRAM output register (microinstruction fetch)
kmcALUCLKEN  out  1  clock ALU/registers/BRG
kmcPCCLKEN  out  1  advance or branch the PC
kmcCRAMWRSTB  out  1  one-clock CRAM write strobe
kmcBUSY  out  1  microcycle in progress
kmcPHASE  out  4  current phase counter (debug)

Behaviour:
- Reset (rst async, or kmcINIT at a clock edge): state=IDLE, phase=0, edge-detect registers=0, all outputs 0.
- Edge detection: kmcSTEP and kmcCRAMWR are registered once. Rise = current & ~previous. A level held high produces exactly one event.
- States:
  - IDLE: no enables asserted.
    - kmcRUN=1 -> RUN.
    - else STEP rise -> STEP.
    - else CRAMWR rise with kmcCRAMOUT=1 -> WRITE.
    - Priority: RUN > STEP > WRITE. A lower-priority rise in the same clock is discarded.
  - RUN: phase counts 0..CLKDIV-1 and wraps.
    - At the end of phase CLKDIV-1, go to IDLE if kmcRUN=0, else stay (phase->0).
    - Dropping RUN mid-cycle always completes the current microcycle.
  - STEP: identical phase sequence to RUN for exactly one microcycle, then IDLE regardless of kmcRUN.
  - WRITE: asserts kmcCRAMWRSTB for exactly one clk, then IDLE. Only entered from IDLE; a CRAMWR rise in RUN/STEP is ignored.
- Phase enables, combinational from state/phase, each exactly one clk per microcycle:
  - kmcCRAMCLKEN: phase 0. Suppressed whenever kmcCRAMIN=1, so the maintenance instruction is executed and the CRAM register is untouched.
  - kmcALUCLKEN: phase CLKDIV-2.
  - kmcPCCLKEN: phase CLKDIV-1.
  - Ordering: fetch, execute, then PC update. The next microcycle's phase-0 fetch uses the updated PC.
- kmcBUSY = (state==RUN | state==STEP).
- kmcPHASE = phase counter; 0 outside RUN/STEP.
- Latency:
  - RUN or STEP rise sampled at edge N -> state changes at edge N+1. First CRAMCLKEN is the clock after that.
  - kmcCRAMWRSTB is high for the clock after the state enters WRITE.
- Mid-operation reset or kmcINIT aborts immediately. An aborted microcycle produces no further enables.
- The phase counter is 4 bits wide, with no overflow beyond CLKDIV-1.

Test Plan:
1. Reset, then kmcRUN=1 held for 3 microcycles with CLKDIV=4 -> CRAMCLKEN at phases 0, ALUCLKEN at phases 2, PCCLKEN at phases 3, repeating every 4 clks. Exactly 3 of each enable when RUN drops at phase 1 of the third microcycle.
2. IDLE, kmcSTEP held high 20 clks -> exactly one microcycle (one each of CRAM/ALU/PC enable); kmcBUSY high 4 clks, then IDLE.
3. STEP with kmcCRAMIN=1 -> ALUCLKEN and PCCLKEN pulse once; CRAMCLKEN never asserted.
4. IDLE, kmcCRAMOUT=1, kmcCRAMWR 0->1 -> single-clk kmcCRAMWRSTB. Same with kmcCRAMOUT=0, or during RUN -> no strobe.
5. RUN active, assert rst asynchronously at phase 1 -> all outputs 0 immediately, kmcPHASE=0. Release with kmcRUN=1 -> restarts at phase 0.
6. kmcRUN and STEP rise on the same clock -> RUN state entered, no STEP microcycle pending after RUN drops. Repeat with CLKDIV=3: ALUCLKEN at phase 1, PCCLKEN at phase 2.

Source files
------------

// File: rtl/kmc_clkctl.sv
// ----------------------------------------------------------------------------
// kmc_clkctl -- KMC11 microcycle clock controller.
//
// Turns the maintenance-register controls (RUN, STEP, CRAM IN/OUT/WR) into
// the per-phase clock enables used by the sequencer and ALU. A microcycle
// is CLKDIV clocks long: fetch at phase 0, execute at phase CLKDIV-2 and
// PC update at phase CLKDIV-1. The next fetch therefore sees the updated PC.
//
// Parameter:
//   CLKDIV        clk cycles per microcycle (3..16)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   kmcINIT       synchronous device initialize (same effect as rst)
//   kmcRUN        run level from the maintenance CSR
//   kmcSTEP       step level; one microcycle per rising edge
//   kmcCRAMIN     execute the maintenance instruction (suppresses fetch)
//   kmcCRAMOUT    CRAM write enable from the maintenance CSR
//   kmcCRAMWR     CRAM write level; one write strobe per rising edge
//   kmcCRAMCLKEN  load CRAM output register (phase 0)
//   kmcALUCLKEN   clock ALU/registers/BRG (phase CLKDIV-2)
//   kmcPCCLKEN    advance or branch the PC (phase CLKDIV-1)
//   kmcCRAMWRSTB  one-clock CRAM write strobe
//   kmcBUSY       microcycle in progress
//   kmcPHASE      current phase (0 outside RUN/STEP)
// ----------------------------------------------------------------------------
module kmc_clkctl #(
   parameter int CLKDIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kmcINIT,
   input  logic       kmcRUN,
   input  logic       kmcSTEP,
   input  logic       kmcCRAMIN,
   input  logic       kmcCRAMOUT,
   input  logic       kmcCRAMWR,
   output logic       kmcCRAMCLKEN,
   output logic       kmcALUCLKEN,
   output logic       kmcPCCLKEN,
   output logic       kmcCRAMWRSTB,
   output logic       kmcBUSY,
   output logic [3:0] kmcPHASE
);

   localparam logic [3:0] PH_ALU  = 4'(CLKDIV - 2);
   localparam logic [3:0] PH_LAST = 4'(CLKDIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STEP  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t     state_q;
   logic [3:0] phase_q;
   logic [3:0] phase_d;
   logic       run_q;
   logic       step_q;
   logic       step_prev_q;
   logic       wr_q;
   logic       wr_prev_q;
   logic       step_rise;
   logic       wr_rise;
   logic       phase_last;

   // Edge detection works on the registered copies, so a rise observed in
   // one clock acts on the next edge and is gone one clock later: a rise
   // that arrives while the FSM is busy is simply lost.
   assign step_rise  = step_q & ~step_prev_q;
   assign wr_rise    = wr_q & ~wr_prev_q;
   assign phase_last = (phase_q == PH_LAST);
   assign phase_d    = phase_last ? 4'd0 : phase_q + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 4'd0;
         run_q       <= 1'b0;
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
         wr_q        <= 1'b0;
         wr_prev_q   <= 1'b0;
      end else if (kmcINIT) begin
         state_q     <= S_IDLE;
         phase_q     <= 4'd0;
         run_q       <= 1'b0;
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
         wr_q        <= 1'b0;
         wr_prev_q   <= 1'b0;
      end else begin
         run_q       <= kmcRUN;
         step_q      <= kmcSTEP;
         step_prev_q <= step_q;
         wr_q        <= kmcCRAMWR;
         wr_prev_q   <= wr_q;

         case (state_q)
            S_IDLE: begin
               phase_q <= 4'd0;
               if (run_q)
                  state_q <= S_RUN;
               else if (step_rise)
                  state_q <= S_STEP;
               else if (wr_rise && kmcCRAMOUT)
                  state_q <= S_WRITE;
            end
            // RUN is only re-examined at the end of a microcycle, so a
            // dropped RUN always lets the current microcycle complete.
            S_RUN: begin
               phase_q <= phase_d;
               if (phase_last && !run_q)
                  state_q <= S_IDLE;
            end
            S_STEP: begin
               phase_q <= phase_d;
               if (phase_last)
                  state_q <= S_IDLE;
            end
            S_WRITE: begin
               phase_q <= 4'd0;
               state_q <= S_IDLE;
            end
            default: begin
               phase_q <= 4'd0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Enables decode directly from the state/phase registers.
   assign kmcBUSY      = (state_q == S_RUN) || (state_q == S_STEP);
   assign kmcCRAMCLKEN = kmcBUSY && (phase_q == 4'd0) && !kmcCRAMIN;
   assign kmcALUCLKEN  = kmcBUSY && (phase_q == PH_ALU);
   assign kmcPCCLKEN   = kmcBUSY && phase_last;
   assign kmcCRAMWRSTB = (state_q == S_WRITE);
   assign kmcPHASE     = phase_q;

endmodule

// File: tb/tb_kmc_clkctl.sv
// ----------------------------------------------------------------------------
// Bench for kmc_clkctl. Two instances: CLKDIV=4 (main) and CLKDIV=3.
// Stimulus pushes every enable/strobe the controller should emit (with its
// clock number and phase) into a per-instance queue; a monitor per instance
// pops one entry whenever an enable or strobe is seen and compares.
// ----------------------------------------------------------------------------
module tb_kmc_clkctl;

   typedef struct {
      int         cyc;
      logic [3:0] en;   // {strobe, pc, alu, cram}
      logic [3:0] ph;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init = 1'b0;

   // CLKDIV=4 instance
   logic run = 1'b0, step = 1'b0, cramin = 1'b0, cramout = 1'b0, cramwr = 1'b0;
   logic cramclken, aluclken, pcclken, wrstb, busy;
   logic [3:0] phase;

   // CLKDIV=3 instance
   logic run3 = 1'b0, step3 = 1'b0;
   logic cramclken3, aluclken3, pcclken3, wrstb3, busy3;
   logic [3:0] phase3;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   ev_t q4[$];
   ev_t q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kmc_clkctl #(.CLKDIV(4)) dut (
      .clk(clk), .rst(rst), .kmcINIT(init),
      .kmcRUN(run), .kmcSTEP(step), .kmcCRAMIN(cramin),
      .kmcCRAMOUT(cramout), .kmcCRAMWR(cramwr),
      .kmcCRAMCLKEN(cramclken), .kmcALUCLKEN(aluclken), .kmcPCCLKEN(pcclken),
      .kmcCRAMWRSTB(wrstb), .kmcBUSY(busy), .kmcPHASE(phase)
   );

   kmc_clkctl #(.CLKDIV(3)) dut3 (
      .clk(clk), .rst(rst), .kmcINIT(init),
      .kmcRUN(run3), .kmcSTEP(step3), .kmcCRAMIN(1'b0),
      .kmcCRAMOUT(1'b0), .kmcCRAMWR(1'b0),
      .kmcCRAMCLKEN(cramclken3), .kmcALUCLKEN(aluclken3), .kmcPCCLKEN(pcclken3),
      .kmcCRAMWRSTB(wrstb3), .kmcBUSY(busy3), .kmcPHASE(phase3)
   );

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_ev(input string nm, input ev_t e, input logic [3:0] en,
                         input logic [3:0] ph);
      compared++;
      if (e.cyc != cyc || e.en !== en || e.ph !== ph) begin
         mismatched++;
         $display("FAIL %s: got cyc=%0d en=%b ph=%0d, expected cyc=%0d en=%b ph=%0d",
                  nm, cyc, en, ph, e.cyc, e.en, e.ph);
      end
   endtask

   // Monitors: sample mid-cycle, on the falling edge.
   always @(negedge clk) begin
      logic [3:0] en;
      ev_t e;
      en = {wrstb, pcclken, aluclken, cramclken};
      if (|en) begin
         if (q4.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL ev4_unexpected: got cyc=%0d en=%b ph=%0d, expected none",
                     cyc, en, phase);
         end else begin
            e = q4.pop_front();
            cmp_ev("ev4", e, en, phase);
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] en;
      ev_t e;
      en = {wrstb3, pcclken3, aluclken3, cramclken3};
      if (|en) begin
         if (q3.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL ev3_unexpected: got cyc=%0d en=%b ph=%0d, expected none",
                     cyc, en, phase3);
         end else begin
            e = q3.pop_front();
            cmp_ev("ev3", e, en, phase3);
         end
      end
   end

   task automatic push_ev(input bit w3, input int cy, input logic [3:0] en,
                          input logic [3:0] ph);
      ev_t e;
      e.cyc = cy;
      e.en  = en;
      e.ph  = ph;
      if (w3) q3.push_back(e);
      else    q4.push_back(e);
   endtask

   // One full microcycle starting (phase 0) at clock s.
   task automatic push_mc(input bit w3, input int s, input int div, input bit no_fetch);
      if (!no_fetch) push_ev(w3, s, 4'b0001, 4'd0);
      push_ev(w3, s + div - 2, 4'b0010, 4'(div - 2));
      push_ev(w3, s + div - 1, 4'b0100, 4'(div - 1));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      int r;
      int nbusy;

      // Reset state
      tick(2);
      chk("rst_outputs", {cramclken, aluclken, pcclken, wrstb, busy}, 0);
      chk("rst_phase", phase, 0);
      rst = 1'b0;
      tick(2);

      // 1: RUN for three microcycles, RUN dropped at phase 1 of the third
      c = cyc;
      run = 1'b1;
      push_mc(0, c + 2, 4, 0);
      push_mc(0, c + 6, 4, 0);
      push_mc(0, c + 10, 4, 0);
      tick(11);
      chk("run_phase1", phase, 1);
      run = 1'b0;
      chk("run_busy", busy, 1);
      tick(5);
      chk("run_idle_busy", busy, 0);
      chk("run_idle_phase", phase, 0);

      // 2: STEP held 20 clocks -> one microcycle, BUSY for 4 clocks
      c = cyc;
      step = 1'b1;
      push_mc(0, c + 2, 4, 0);
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (busy) nbusy++;
      end
      chk("step_busy_clks", nbusy, 4);
      step = 1'b0;
      tick(2);

      // 3: STEP with CRAMIN -> no fetch enable
      c = cyc;
      step = 1'b1;
      cramin = 1'b1;
      push_mc(0, c + 2, 4, 1);
      tick(8);
      step = 1'b0;
      cramin = 1'b0;
      tick(2);

      // 4: CRAM write strobe from IDLE; none with CRAMOUT=0 or during RUN
      c = cyc;
      cramout = 1'b1;
      cramwr = 1'b1;
      push_ev(0, c + 2, 4'b1000, 4'd0);
      tick(4);
      chk("wr_done_busy", busy, 0);
      cramwr = 1'b0;
      tick(2);
      cramout = 1'b0;
      cramwr = 1'b1;
      tick(4);
      cramwr = 1'b0;
      tick(2);
      c = cyc;
      cramout = 1'b1;
      run = 1'b1;
      push_mc(0, c + 2, 4, 0);
      tick(2);
      run = 1'b0;
      cramwr = 1'b1;
      tick(8);
      cramwr = 1'b0;
      cramout = 1'b0;
      tick(2);

      // 5: asynchronous reset at phase 1, then restart with RUN held
      c = cyc;
      run = 1'b1;
      push_mc(0, c + 2, 4, 0);
      push_ev(0, c + 6, 4'b0001, 4'd0);
      tick(7);
      chk("pre_rst_phase", phase, 1);
      rst = 1'b1;
      #1;
      chk("arst_outputs", {cramclken, aluclken, pcclken, wrstb, busy}, 0);
      chk("arst_phase", phase, 0);
      tick(2);
      rst = 1'b0;
      r = cyc;
      push_mc(0, r + 2, 4, 0);
      tick(2);
      chk("restart_phase", phase, 0);
      chk("restart_busy", busy, 1);
      run = 1'b0;
      tick(6);

      // kmcINIT at phase 1 aborts the microcycle
      c = cyc;
      run = 1'b1;
      push_ev(0, c + 2, 4'b0001, 4'd0);
      tick(3);
      init = 1'b1;
      tick(1);
      chk("init_busy", busy, 0);
      chk("init_phase", phase, 0);
      init = 1'b0;
      run = 1'b0;
      tick(4);

      // 6: RUN and STEP rise together -> RUN wins, no STEP left pending
      c = cyc;
      run = 1'b1;
      step = 1'b1;
      push_mc(0, c + 2, 4, 0);
      tick(2);
      run = 1'b0;
      tick(10);
      chk("prio_idle_busy", busy, 0);
      step = 1'b0;
      tick(2);

      // 6b: same on CLKDIV=3, two microcycles
      c = cyc;
      run3 = 1'b1;
      step3 = 1'b1;
      push_mc(1, c + 2, 3, 0);
      push_mc(1, c + 5, 3, 0);
      tick(5);
      chk("div3_busy", busy3, 1);
      run3 = 1'b0;
      tick(7);
      chk("div3_idle_busy", busy3, 0);
      step3 = 1'b0;
      tick(3);

      chk("q4_left", q4.size(), 0);
      chk("q3_left", q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
